// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid handshake with one
// outstanding request, and feeds decode through a registered output plus a one-entry skid buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        ID_branch_en_i,
  input  logic [31:0] ID_branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        IF_valid_o,
  output logic [31:0] IF_Instruction_o,
  output logic [31:0] IF_PC_o
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] inflight_pc_r, inflight_pc_s;
  logic        out_valid_r, out_valid_s;
  logic [31:0] out_insn_r, out_insn_s;
  logic [31:0] out_pc_r, out_pc_s;
  logic        sk_valid_r, sk_valid_s;
  logic [31:0] sk_insn_r, sk_insn_s;
  logic [31:0] sk_pc_r, sk_pc_s;
  logic        run_r;

  logic        gnt_s;
  logic        consume_s;
  logic        deliver_s;

  // run_r keeps the request low in the cycle directly following a reset edge.
  assign imem_req_o       = run_r && (state_r == ST_REQ) && !sk_valid_r;
  assign imem_addr_o      = pc_r;
  assign IF_valid_o       = out_valid_r;
  assign IF_Instruction_o = out_insn_r;
  assign IF_PC_o          = out_pc_r;

  assign gnt_s     = imem_req_o && imem_gnt_i;
  assign consume_s = out_valid_r && !stall_i;
  assign deliver_s = (state_r == ST_WAIT) && imem_rvalid_i && !ID_branch_en_i;

  // Next-state and next-PC selection; a redirect steers any in-flight fetch into DRAIN.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    inflight_pc_s = inflight_pc_r;
    case (state_r)
      ST_REQ: begin
        if (gnt_s) begin
          state_s = ID_branch_en_i ? ST_DRAIN : ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_s = ST_REQ;
        end else begin
          state_s = ID_branch_en_i ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid_i) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_REQ;
    endcase
    if (gnt_s) begin
      inflight_pc_s = pc_r;
    end else begin
      inflight_pc_s = inflight_pc_r;
    end
    if (ID_branch_en_i) begin
      pc_s = {ID_branch_addr_i[31:2], 2'b00};
    end else if (gnt_s) begin
      pc_s = pc_r + 32'd4;
    end else begin
      pc_s = pc_r;
    end
  end

  // Output register and skid buffer; a response only lands in SK when OUT stays occupied.
  always_comb begin
    out_valid_s = out_valid_r;
    out_insn_s  = out_insn_r;
    out_pc_s    = out_pc_r;
    sk_valid_s  = sk_valid_r;
    sk_insn_s   = sk_insn_r;
    sk_pc_s     = sk_pc_r;
    if (ID_branch_en_i) begin
      out_valid_s = 1'b0;
      out_insn_s  = NOP_INSN;
      sk_valid_s  = 1'b0;
    end else if (consume_s) begin
      if (sk_valid_r) begin
        out_valid_s = 1'b1;
        out_insn_s  = sk_insn_r;
        out_pc_s    = sk_pc_r;
        if (deliver_s) begin
          sk_valid_s = 1'b1;
          sk_insn_s  = imem_rdata_i;
          sk_pc_s    = inflight_pc_r;
        end else begin
          sk_valid_s = 1'b0;
        end
      end else if (deliver_s) begin
        out_valid_s = 1'b1;
        out_insn_s  = imem_rdata_i;
        out_pc_s    = inflight_pc_r;
      end else begin
        out_valid_s = 1'b0;
        out_insn_s  = NOP_INSN;
      end
    end else if (deliver_s) begin
      if (out_valid_r) begin
        sk_valid_s = 1'b1;
        sk_insn_s  = imem_rdata_i;
        sk_pc_s    = inflight_pc_r;
      end else begin
        out_valid_s = 1'b1;
        out_insn_s  = imem_rdata_i;
        out_pc_s    = inflight_pc_r;
      end
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r       <= ST_REQ;
      pc_r          <= RESET_PC;
      inflight_pc_r <= RESET_PC;
      out_valid_r   <= 1'b0;
      out_insn_r    <= NOP_INSN;
      out_pc_r      <= 32'h0000_0000;
      sk_valid_r    <= 1'b0;
      sk_insn_r     <= NOP_INSN;
      sk_pc_r       <= 32'h0000_0000;
      run_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      inflight_pc_r <= inflight_pc_s;
      out_valid_r   <= out_valid_s;
      out_insn_r    <= out_insn_s;
      out_pc_r      <= out_pc_s;
      sk_valid_r    <= sk_valid_s;
      sk_insn_r     <= sk_insn_s;
      sk_pc_r       <= sk_pc_s;
      run_r         <= 1'b1;
    end
  end

endmodule
